// File: rtl/bus_arbiter_16to1_8bit.sv
// Round-robin gather of sixteen 8-bit lines into one registered output with source index.
// One-cycle latency; grants only when the output register is empty or draining, so a stalled consumer holds everything.
module bus_arbiter_16to1_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic [7:0]  in4,
  input  logic [7:0]  in5,
  input  logic [7:0]  in6,
  input  logic [7:0]  in7,
  input  logic [7:0]  in8,
  input  logic [7:0]  in9,
  input  logic [7:0]  in10,
  input  logic [7:0]  in11,
  input  logic [7:0]  in12,
  input  logic [7:0]  in13,
  input  logic [7:0]  in14,
  input  logic [7:0]  in15,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [7:0]  out,
  output logic [3:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [7:0]  lines [16];
  logic [3:0]  ptr;
  logic [3:0]  win;
  logic [3:0]  cand;
  logic        found;
  logic        load;

  assign lines[0]  = in0;
  assign lines[1]  = in1;
  assign lines[2]  = in2;
  assign lines[3]  = in3;
  assign lines[4]  = in4;
  assign lines[5]  = in5;
  assign lines[6]  = in6;
  assign lines[7]  = in7;
  assign lines[8]  = in8;
  assign lines[9]  = in9;
  assign lines[10] = in10;
  assign lines[11] = in11;
  assign lines[12] = in12;
  assign lines[13] = in13;
  assign lines[14] = in14;
  assign lines[15] = in15;

  assign load = !out_valid || out_ready;

  // Search ptr+1 .. ptr+16; the 4-bit wrap makes the last candidate ptr itself.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    gnt   = '0;
    for (int i = 1; i <= 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (rst_n && load && found) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 8'h00;
      out_sel   <= 4'd0;
      out_valid <= 1'b0;
      ptr       <= 4'd15;
    end else if (load) begin
      if (found) begin
        out       <= lines[win];
        out_sel   <= win;
        out_valid <= 1'b1;
        ptr       <= win;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_arbiter_16to1_8bit.md
# bus_arbiter_16to1_8bit

Gathers sixteen 8-bit source lines onto one registered 8-bit output: the collecting counterpart to the 16-line demultiplexer. A round-robin arbiter picks one requesting line per accepted transfer. The block captures that line's data and source index into an output register. The register drains through a valid/ready handshake toward the bus or the next stage.

## Interface
- Parameters: none. Data width is fixed at 8 bits and line count at 16.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0 .. in15  input  8 each  source data lines; inN is sampled only when gnt[N] is high
- req  input  16  per-line request; req[N] is high while inN holds data to transfer
- gnt  output  16  one-hot, combinational; gnt[N] high means inN is captured at this rising edge
- out  output  8  registered data
- out_sel  output  4  registered index of the line that produced out
- out_valid  output  1  out/out_sel hold an untaken transfer
- out_ready  input  1  consumer accepts out when out_valid && out_ready at a rising edge

## Operation
- load = !out_valid || out_ready. The register can take new data when empty or when being drained in the same cycle.
- Arbitration pointer ptr (4 bits) records the last granted line. Search order is ptr+1, ptr+2, … mod 16, ending at ptr itself.
- When load && req != 0:
  - gnt = one-hot of the first requesting line in search order.
  - At the edge: out <= that line's data, out_sel <= its index, out_valid <= 1, ptr <= its index.
- When load && req == 0:
  - gnt = 0.
  - At the edge: out_valid <= 0 if out_ready or already empty; out and out_sel keep their old values; ptr unchanged.
- When !load (out_valid && !out_ready):
  - gnt = 0.
  - out, out_sel, out_valid and ptr all hold.
- Sources hold req and data until they see their gnt, then update on the following cycle.
- A single requester is granted every cycle; round-robin does not starve it.
- Wrap-around: with ptr = 15, the search starts at line 0.
- A request arriving while the register is stalled waits; arbitration happens only in the cycle load is high.

## Timing
- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - out = 8'h00, out_sel = 0, out_valid = 0, ptr = 15 (so line 0 has first priority).
  - A held transfer is discarded and gnt drops immediately.
- Latency: request sampled at edge k appears on out / out_valid after edge k (one cycle).
- Throughput: one transfer per cycle while out_ready = 1 and req != 0.
- Simultaneous drain and load: a same-edge handshake and new capture leave out_valid at 1 with the new data; there is no bubble.
- gnt depends combinationally on req, out_valid, out_ready and ptr, and is stable only after those settle. No combinational path exists from in0..in15 to any output.
- All outputs other than gnt are registered.

## Test plan
- Reset checks:
  - Assert rst_n = 0 mid-stream with out_valid = 1 -> out = 0, out_sel = 0, out_valid = 0 immediately.
  - After release, req = 16'hFFFF gives gnt = 16'h0001 first.
- Round-robin sweep:
  - Set inN = N*16+7, req = 16'hFFFF, out_ready = 1 -> over 16 cycles, out_sel is 0,1,…,15 and out is 8'h07,8'h17,…,8'hF7.
  - Cycle 17 yields out_sel = 0 again (wrap).
- Backpressure:
  - Set req = 16'h0110 and drop out_ready after the first capture (out_sel = 4) -> out = in4 held, gnt = 0 for 5 stalled cycles.
  - Raise out_ready -> next capture is out_sel = 8.
- Single requester: req = 16'h8000, in15 = 8'hA5, out_ready = 1 -> gnt[15] high every cycle, out = 8'hA5, out_sel = 15, out_valid stays 1.
- Idle drain: after one transfer set req = 0 with out_ready = 1 -> out_valid = 0 next cycle, out unchanged, gnt = 0.
- Sparse fairness: req = 16'h0003 continuously, out_ready = 1 -> out_sel alternates 0,1,0,1; neither line wins twice in a row.
